// File: rtl/lane_latch_scheduler.sv
// Round-robin latch-window scheduler: grants one lane at a time, holds its latch
// enable open for EN_CYCLES cycles, then closes with a done or abort pulse.
module lane_latch_scheduler #(
  parameter int SIZE      = 8,
  parameter int EN_CYCLES = 2
) (
  input  logic                    i_clk,
  input  logic                    i_srst,
  input  logic [SIZE-1:0]         i_req,
  input  logic                    i_hold,
  output logic [SIZE-1:0]         o_gnt,
  output logic [SIZE-1:0]         o_en,
  output logic [$clog2(SIZE)-1:0] o_lane,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_abort,
  output logic [1:0]              o_state
);

  localparam int LW = $clog2(SIZE);
  localparam logic [3:0]      CNT_LAST  = 4'(EN_CYCLES - 1);
  localparam logic [LW-1:0]   LANE_LAST = LW'(SIZE - 1);
  localparam logic [SIZE-1:0] ONE_HOT0  = SIZE'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_OPEN  = 2'd1,
    S_CLOSE = 2'd2
  } state_t;

  state_t          state_q;
  logic [LW-1:0]   ptr_q;
  logic [LW-1:0]   lane_q;
  logic [3:0]      cnt_q;
  logic [SIZE-1:0] gnt_q;
  logic [SIZE-1:0] en_q;
  logic            busy_q;
  logic            done_q;
  logic            abort_q;

  logic [LW-1:0]   pick_d;
  logic            found_d;
  logic [LW-1:0]   cand;

  // First requesting lane at or above ptr, wrapping past SIZE-1 back to 0.
  always_comb begin
    pick_d  = '0;
    found_d = 1'b0;
    cand    = '0;
    for (int i = 0; i < SIZE; i++) begin
      cand = LW'((int'(ptr_q) + i) % SIZE);
      if (!found_d && i_req[cand]) begin
        pick_d  = cand;
        found_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_srst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      lane_q  <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      en_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      abort_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!i_hold && found_d) begin
            state_q <= S_OPEN;
            lane_q  <= pick_d;
            gnt_q   <= ONE_HOT0 << pick_d;
            en_q    <= ONE_HOT0 << pick_d;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
          end
        end
        S_OPEN: begin
          // Losing the request wins over reaching the last cycle of the window.
          if (!i_req[lane_q]) begin
            state_q <= S_CLOSE;
            en_q    <= '0;
            abort_q <= 1'b1;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= S_CLOSE;
            en_q    <= '0;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        S_CLOSE: begin
          state_q <= S_IDLE;
          gnt_q   <= '0;
          busy_q  <= 1'b0;
          lane_q  <= '0;
          cnt_q   <= '0;
          ptr_q   <= (lane_q == LANE_LAST) ? '0 : lane_q + LW'(1);
        end
        default: begin
          state_q <= S_IDLE;
          gnt_q   <= '0;
          en_q    <= '0;
          busy_q  <= 1'b0;
          lane_q  <= '0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign o_gnt   = gnt_q;
  assign o_en    = en_q;
  assign o_lane  = lane_q;
  assign o_busy  = busy_q;
  assign o_done  = done_q;
  assign o_abort = abort_q;
  assign o_state = state_q;

`ifndef SYNTHESIS
  a_done_abort_excl : assert property (@(posedge i_clk) disable iff (!i_srst)
    !(done_q && abort_q));
  a_en_onehot0 : assert property (@(posedge i_clk) disable iff (!i_srst)
    $onehot0(en_q));
  a_en_only_open : assert property (@(posedge i_clk) disable iff (!i_srst)
    (en_q != '0) |-> (state_q == S_OPEN));
  a_pulse_only_close : assert property (@(posedge i_clk) disable iff (!i_srst)
    (done_q || abort_q) |-> (state_q == S_CLOSE));
`endif

endmodule

// File: tb/tb_lane_latch_scheduler.sv
// Bench for lane_latch_scheduler: directed scenarios plus randomized traffic
// compared cycle by cycle against a window-countdown reference model.
module tb_lane_latch_scheduler;

  localparam int SIZE      = 8;
  localparam int EN_CYCLES = 2;
  localparam int LW        = $clog2(SIZE);

  logic            clk;
  logic            srst;
  logic [SIZE-1:0] req;
  logic            hold;
  logic [SIZE-1:0] o_gnt;
  logic [SIZE-1:0] o_en;
  logic [LW-1:0]   o_lane;
  logic            o_busy;
  logic            o_done;
  logic            o_abort;
  logic [1:0]      o_state;

  int checks = 0;
  int errors = 0;

  // Reference model: m_left counts remaining window cycles (0 = idle,
  // EN_CYCLES+1..2 = latch open, 1 = closing cycle).
  int              m_ptr, m_left, m_lane;
  bit              m_cut;
  logic [SIZE-1:0] exp_gnt, exp_en;
  logic [LW-1:0]   exp_lane;
  logic            exp_busy, exp_done, exp_abort;
  logic [LW-1:0]   exp_q[$];

  lane_latch_scheduler #(.SIZE(SIZE), .EN_CYCLES(EN_CYCLES)) dut (
    .i_clk   (clk),
    .i_srst  (srst),
    .i_req   (req),
    .i_hold  (hold),
    .o_gnt   (o_gnt),
    .o_en    (o_en),
    .o_lane  (o_lane),
    .o_busy  (o_busy),
    .o_done  (o_done),
    .o_abort (o_abort),
    .o_state (o_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    logic [SIZE-1:0] one;
    bit found;
    one = 1;
    @(posedge clk);
    if (!srst) begin
      m_ptr = 0; m_left = 0; m_lane = 0; m_cut = 0;
    end else if (m_left == 0) begin
      if (!hold && req != 0) begin
        found = 0;
        for (int k = 0; k < SIZE; k++) begin
          if (!found && req[(m_ptr + k) % SIZE]) begin
            m_lane = (m_ptr + k) % SIZE;
            found = 1;
          end
        end
        m_left = EN_CYCLES + 1;
        m_cut  = 0;
      end
    end else if (m_left > 1) begin
      if (!req[m_lane]) begin
        m_left = 1;
        m_cut  = 1;
      end else begin
        m_left = m_left - 1;
      end
    end else begin
      m_ptr  = (m_lane + 1) % SIZE;
      m_left = 0;
      m_lane = 0;
    end
    exp_busy  = (m_left != 0);
    exp_gnt   = exp_busy ? (one << m_lane) : '0;
    exp_en    = (m_left > 1) ? (one << m_lane) : '0;
    exp_lane  = LW'(m_lane);
    exp_done  = (m_left == 1) && !m_cut;
    exp_abort = (m_left == 1) && m_cut;
    #1;
  endtask

  task automatic do_reset();
    srst = 1'b0;
    req  = '0;
    hold = 1'b0;
    step();
    srst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({o_gnt, o_en, o_lane, o_busy, o_done, o_abort, o_state} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: gnt=%h en=%h lane=%0d busy=%b done=%b abort=%b state=%0d, required all zero",
               o_gnt, o_en, o_lane, o_busy, o_done, o_abort, o_state);
    end
  endtask

  task automatic test_single();
    do_reset();
    req = 8'h08;
    step();
    checks++;
    if (o_en !== 8'h08) begin errors++; $display("FAIL single_en1: got %h required 08", o_en); end
    step();
    checks++;
    if (o_en !== 8'h08) begin errors++; $display("FAIL single_en2: got %h required 08", o_en); end
    step();
    checks++;
    if (o_en !== 8'h00 || o_gnt !== 8'h08 || o_done !== 1'b1) begin
      errors++;
      $display("FAIL single_close: en=%h gnt=%h done=%b required en=00 gnt=08 done=1", o_en, o_gnt, o_done);
    end
    req = '0;
    step();
    checks++;
    if (o_busy !== 1'b0 || o_done !== 1'b0) begin
      errors++; $display("FAIL single_idle: busy=%b done=%b required 0 0", o_busy, o_done);
    end
  endtask

  task automatic test_rotation();
    int last_cyc, n_grants;
    logic [SIZE-1:0] prev_en;
    do_reset();
    for (int l = 0; l < 10; l++) exp_q.push_back(LW'(l % SIZE));
    req = 8'hFF;
    prev_en = '0;
    last_cyc = -1;
    n_grants = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (o_en !== '0 && prev_en === '0) begin
        n_grants++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rotation_extra: unexpected grant lane %0d", o_lane);
        end else if (o_lane !== exp_q[0] || o_en !== (SIZE'(1) << exp_q[0])) begin
          errors++; $display("FAIL rotation_order: lane=%0d en=%h required lane %0d", o_lane, o_en, exp_q[0]);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        if (last_cyc >= 0) begin
          checks++;
          if (c - last_cyc != EN_CYCLES + 2) begin
            errors++; $display("FAIL rotation_spacing: got %0d cycles required %0d", c - last_cyc, EN_CYCLES + 2);
          end
        end
        last_cyc = c;
      end
      prev_en = o_en;
    end
    checks++;
    if (n_grants != 10 || exp_q.size() != 0) begin
      errors++; $display("FAIL rotation_count: got %0d grants required 10", n_grants);
    end
    exp_q.delete();
    req = '0;
  endtask

  task automatic test_wrap();
    do_reset();
    req = 8'h80;
    step();
    checks++;
    if (o_lane !== 3'd7 || o_en !== 8'h80) begin
      errors++; $display("FAIL wrap_grant7: lane=%0d en=%h required 7 80", o_lane, o_en);
    end
    req = 8'h81;
    step();
    checks++;
    if (o_en !== 8'h80 || o_lane !== 3'd7) begin
      errors++; $display("FAIL wrap_hold7: lane=%0d en=%h required 7 80", o_lane, o_en);
    end
    step();
    checks++;
    if (o_done !== 1'b1 || o_gnt !== 8'h80) begin
      errors++; $display("FAIL wrap_done: done=%b gnt=%h required 1 80", o_done, o_gnt);
    end
    step();
    step();
    checks++;
    if (o_en !== 8'h01 || o_lane !== 3'd0) begin
      errors++; $display("FAIL wrap_next: lane=%0d en=%h required 0 01", o_lane, o_en);
    end
    req = '0;
  endtask

  task automatic test_abort();
    do_reset();
    req = 8'h08;
    step();
    checks++;
    if (o_en !== 8'h08) begin errors++; $display("FAIL abort_grant3: en=%h required 08", o_en); end
    req = 8'h00;
    step();
    checks++;
    if (o_abort !== 1'b1 || o_done !== 1'b0 || o_en !== 8'h00 || o_gnt !== 8'h08 || o_state !== 2'd2) begin
      errors++;
      $display("FAIL abort_close: abort=%b done=%b en=%h gnt=%h state=%0d required 1 0 00 08 2",
               o_abort, o_done, o_en, o_gnt, o_state);
    end
    req = 8'hFF;
    step();
    checks++;
    if (o_busy !== 1'b0 || o_abort !== 1'b0) begin
      errors++; $display("FAIL abort_idle: busy=%b abort=%b required 0 0", o_busy, o_abort);
    end
    step();
    checks++;
    if (o_lane !== 3'd4 || o_en !== 8'h10) begin
      errors++; $display("FAIL abort_ptr: lane=%0d en=%h required 4 10", o_lane, o_en);
    end
    req = '0;
  endtask

  task automatic test_hold();
    do_reset();
    hold = 1'b1;
    req  = 8'h01;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (o_busy !== 1'b0 || o_en !== 8'h00) begin
        errors++; $display("FAIL hold_blocks: busy=%b en=%h required 0 00", o_busy, o_en);
      end
    end
    hold = 1'b0;
    step();
    checks++;
    if (o_en !== 8'h01) begin errors++; $display("FAIL hold_release: en=%h required 01", o_en); end
    hold = 1'b1;
    step();
    checks++;
    if (o_en !== 8'h01) begin errors++; $display("FAIL hold_in_open: en=%h required 01", o_en); end
    step();
    checks++;
    if (o_done !== 1'b1 || o_abort !== 1'b0) begin
      errors++; $display("FAIL hold_done: done=%b abort=%b required 1 0", o_done, o_abort);
    end
    hold = 1'b0;
    req  = '0;
  endtask

  task automatic test_reset_mid_open();
    do_reset();
    req = 8'h20;
    step();
    checks++;
    if (o_en !== 8'h20 || o_lane !== 3'd5) begin
      errors++; $display("FAIL rstmid_grant5: lane=%0d en=%h required 5 20", o_lane, o_en);
    end
    srst = 1'b0;
    step();
    checks++;
    if ({o_gnt, o_en, o_lane, o_busy, o_done, o_abort} !== '0) begin
      errors++;
      $display("FAIL rstmid_clear: gnt=%h en=%h lane=%0d busy=%b done=%b abort=%b required all zero",
               o_gnt, o_en, o_lane, o_busy, o_done, o_abort);
    end
    srst = 1'b1;
    req  = 8'h24;
    step();
    checks++;
    if (o_done !== 1'b0 || o_abort !== 1'b0 || o_lane !== 3'd2 || o_en !== 8'h04) begin
      errors++;
      $display("FAIL rstmid_rescan: done=%b abort=%b lane=%0d en=%h required 0 0 2 04",
               o_done, o_abort, o_lane, o_en);
    end
    req = '0;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) req = SIZE'($urandom);
      hold = ($urandom_range(0, 7) == 0);
      srst = ($urandom_range(0, 149) != 0);
      step();
      checks++;
      if (o_gnt !== exp_gnt || o_en !== exp_en || o_lane !== exp_lane || o_busy !== exp_busy ||
          o_done !== exp_done || o_abort !== exp_abort) begin
        errors++;
        $display("FAIL random_cycle%0d: gnt=%h en=%h lane=%0d busy=%b done=%b abort=%b required %h %h %0d %b %b %b",
                 c, o_gnt, o_en, o_lane, o_busy, o_done, o_abort,
                 exp_gnt, exp_en, exp_lane, exp_busy, exp_done, exp_abort);
      end
      checks++;
      if (!$onehot0(o_en) || (o_done && o_abort)) begin
        errors++; $display("FAIL random_invariant%0d: en=%h done=%b abort=%b", c, o_en, o_done, o_abort);
      end
    end
    srst = 1'b1;
    req  = '0;
    hold = 1'b0;
  endtask

  initial begin
    srst = 1'b0;
    req  = '0;
    hold = 1'b0;
    m_ptr = 0; m_left = 0; m_lane = 0; m_cut = 0;
    test_reset();
    test_single();
    test_rotation();
    test_wrap();
    test_abort();
    test_hold();
    test_reset_mid_open();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
